sn74ls161_counter: RTL and testbench

//   Model of a 74LS161 synchronous presettable binary counter: async clear,

---
 rtl/sn74ls161_counter_pkg.sv | 16 +
 rtl/sn74ls161_counter_if.sv | 32 +++
 rtl/sn74ls161_counter_bit_stage.sv | 40 ++++
 rtl/sn74ls161_counter.sv | 51 +++++
 tb/tb_sn74ls161_counter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/sn74ls161_counter_pkg.sv
// Shared definitions for the 74LS161-style presettable counter.
//   LS161_DEFAULT_WIDTH : width of the real chip (4 bits)
//   all_ones(width)     : mask with the low 'width' bits set (width 1..16),
//                         used for the terminal-count compare behind RCO
package ls_counter_pkg;

  localparam int LS161_DEFAULT_WIDTH = 4;

  function automatic logic [15:0] all_ones(input int width);
    logic [16:0] mask;
    // 17-bit intermediate so width == 16 still yields 16'hFFFF
    mask = (17'd1 << width) - 17'd1;
    return mask[15:0];
  endfunction

endpackage

// File: rtl/sn74ls161_counter_if.sv
// Data/control bundle of one counter stage.
//   in_LOAD_n : sync active-low parallel load
//   in_ENP    : count enable P
//   in_ENT    : count enable T, also gates RCO
//   in_D      : parallel load data (bit0 = chip A)
//   out_Q     : counter state (bit0 = chip QA)
//   out_RCO   : ripple carry out
// master = whoever drives the controls, slave = the counter itself.
interface sn74ls161_counter_if
  import ls_counter_pkg::*;
#(
  parameter int WIDTH = LS161_DEFAULT_WIDTH
) ();

  logic             in_LOAD_n;
  logic             in_ENP;
  logic             in_ENT;
  logic [WIDTH-1:0] in_D;
  logic [WIDTH-1:0] out_Q;
  logic             out_RCO;

  modport master (
    output in_LOAD_n, in_ENP, in_ENT, in_D,
    input  out_Q, out_RCO
  );

  modport slave (
    input  in_LOAD_n, in_ENP, in_ENT, in_D,
    output out_Q, out_RCO
  );

endinterface

// File: rtl/sn74ls161_counter_bit_stage.sv
// One bit of the counter: a flop with async clear, a load mux and a toggle
// input, matching the chip's internal JK/toggle chain.
//   clk      : rising-edge clock
//   rst_n    : async active-low clear
//   load_n_i : sync active-low load (overrides toggle)
//   d_i      : load data for this bit
//   toggle_i : invert this bit at the next edge (enables AND lower bits all 1)
//   q_o      : bit state
module ls161_bit_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic load_n_i,
  input  logic d_i,
  input  logic toggle_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (!load_n_i) begin
      q_d = d_i;
    end else if (toggle_i) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sn74ls161_counter.sv
// 74LS161-style synchronous presettable binary counter.
//   clk   : rising-edge clock
//   rst_n : async active-low clear
//   bus   : slave side of sn74ls161_counter_if (LOAD_n, ENP, ENT, D in;
//           Q, RCO out)
// Priority at an edge: load, then count (ENP & ENT), else hold.
// RCO = ENT & (Q == all ones), purely combinational so stages cascade by
// wiring RCO into the next stage's ENT.
module sn74ls161_counter
  import ls_counter_pkg::*;
#(
  parameter int WIDTH = LS161_DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  sn74ls161_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] q_vec;
  // low_ones[i] is high when every bit below i is 1 (bit 0 has none below)
  logic [WIDTH-1:0] low_ones;
  logic             count_en;

  assign count_en    = bus.in_ENP & bus.in_ENT;
  assign low_ones[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign low_ones[gi] = low_ones[gi-1] & q_vec[gi-1];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      ls161_bit_stage u_bit (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_n_i (bus.in_LOAD_n),
        .d_i      (bus.in_D[gi]),
        .toggle_i (count_en & low_ones[gi]),
        .q_o      (q_vec[gi])
      );
    end
  endgenerate

  assign bus.out_Q   = q_vec;
  // ENP and LOAD_n deliberately play no part in the carry output
  assign bus.out_RCO = bus.in_ENT & (q_vec == ONES);

endmodule

// File: tb/tb_sn74ls161_counter.sv
// Bench for sn74ls161_counter: a single 4-bit stage plus two 4-bit stages
// cascaded into an 8-bit counter, both compared each cycle against an
// arithmetic model of the counting rules.
module tb_sn74ls161_counter;
  import ls_counter_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   m = 0;   // single-stage model value
  int   cm = 0;  // cascaded 8-bit model value

  always #5 clk = ~clk;

  sn74ls161_counter_if #(.WIDTH(W)) dut_if ();
  sn74ls161_counter_if #(.WIDTH(4)) lo_if ();
  sn74ls161_counter_if #(.WIDTH(4)) hi_if ();

  assign hi_if.in_ENT    = lo_if.out_RCO;
  assign hi_if.in_ENP    = lo_if.in_ENP;
  assign hi_if.in_LOAD_n = lo_if.in_LOAD_n;

  sn74ls161_counter #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(dut_if));
  sn74ls161_counter #(.WIDTH(4)) u_lo  (.clk(clk), .rst_n(rst_n), .bus(lo_if));
  sn74ls161_counter #(.WIDTH(4)) u_hi  (.clk(clk), .rst_n(rst_n), .bus(hi_if));

  function automatic int model(int cur, logic load_n, logic enp, logic ent,
                               int d, int modv);
    if (load_n === 1'b0) return d;
    if (enp === 1'b1 && ent === 1'b1) return (cur + 1) % modv;
    return cur;
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    logic [7:0] cq;
    cq = {hi_if.out_Q, lo_if.out_Q};
    check({tag, ".Q"},     16'(dut_if.out_Q), 16'(m));
    check({tag, ".RCO"},   16'(dut_if.out_RCO),
          16'(dut_if.in_ENT === 1'b1 && m == 15));
    check({tag, ".CQ"},    16'(cq), 16'(cm));
    check({tag, ".LORCO"}, 16'(lo_if.out_RCO),
          16'(lo_if.in_ENT === 1'b1 && (cm % 16) == 15));
    check({tag, ".HIRCO"}, 16'(hi_if.out_RCO),
          16'(lo_if.in_ENT === 1'b1 && cm == 255));
    $display("%-10s rst_n=%b Q=%h RCO=%b | CQ=%h HIRCO=%b", tag, rst_n,
             dut_if.out_Q, dut_if.out_RCO, cq, hi_if.out_RCO);
  endtask

  // One clock edge: advance both models from the inputs held at the edge,
  // then sample 1 time unit after the edge.
  task automatic tick(string tag);
    int nm;
    int ncm;
    nm  = model(m, dut_if.in_LOAD_n, dut_if.in_ENP, dut_if.in_ENT,
                int'(dut_if.in_D), 16);
    ncm = model(cm, lo_if.in_LOAD_n, lo_if.in_ENP, lo_if.in_ENT,
                int'({hi_if.in_D, lo_if.in_D}), 256);
    @(posedge clk);
    #1;
    if (rst_n === 1'b1) begin
      m  = nm;
      cm = ncm;
    end
    check_all(tag);
  endtask

  task automatic set_dut(logic load_n, logic enp, logic ent, logic [3:0] d);
    dut_if.in_LOAD_n = load_n;
    dut_if.in_ENP    = enp;
    dut_if.in_ENT    = ent;
    dut_if.in_D      = d;
  endtask

  task automatic set_casc(logic load_n, logic enp, logic ent, logic [7:0] d);
    lo_if.in_LOAD_n = load_n;
    lo_if.in_ENP    = enp;
    lo_if.in_ENT    = ent;
    lo_if.in_D      = d[3:0];
    hi_if.in_D      = d[7:4];
  endtask

  initial begin
    // 1: reset held with load requested: Q stays 0, RCO 0
    rst_n = 1'b0;
    m = 0;
    cm = 0;
    set_dut(1'b0, 1'b1, 1'b1, 4'hA);
    set_casc(1'b0, 1'b1, 1'b1, 8'hFE);
    for (int i = 0; i < 3; i++) tick("reset");

    // 2: free count through a full wrap
    @(negedge clk);
    rst_n = 1'b1;
    set_dut(1'b1, 1'b1, 1'b1, 4'h0);
    set_casc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 17; i++) tick("count");

    // 3: load beats count, then count resumes
    set_dut(1'b0, 1'b1, 1'b1, 4'h9);
    tick("load9");
    set_dut(1'b1, 1'b1, 1'b1, 4'h9);
    tick("after9");

    // 4: hold at all-ones; RCO tracks ENT only
    set_dut(1'b0, 1'b0, 1'b1, 4'hF);
    tick("loadF");
    set_dut(1'b1, 1'b0, 1'b1, 4'h0);
    tick("holdP0");
    dut_if.in_ENT = 1'b0;
    #1;
    check("rco_comb", 16'(dut_if.out_RCO), 16'd0);
    tick("holdT0");

    // 5: async clear mid-cycle, count resumes from 0
    set_dut(1'b0, 1'b1, 1'b1, 4'h4);
    tick("load4");
    set_dut(1'b1, 1'b1, 1'b1, 4'h0);
    tick("cnt5");
    tick("cnt6");
    #2;
    rst_n = 1'b0;
    m = 0;
    cm = 0;
    #1;
    check_all("async_clr");
    #1;
    rst_n = 1'b1;
    tick("resume1");

    // 6: cascade across the lower stage's wrap
    set_casc(1'b0, 1'b1, 1'b1, 8'hFE);
    tick("cload");
    set_casc(1'b1, 1'b1, 1'b1, 8'h00);
    tick("cFF");
    check("casc_ff", 16'({hi_if.out_Q, lo_if.out_Q, hi_if.out_RCO}), 16'h1FF);
    tick("c00");

    // randomized mix including occasional async clears
    for (int i = 0; i < 200; i++) begin
      set_dut(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
              4'($urandom));
      set_casc(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) != 0), 8'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        m = 0;
        cm = 0;
        #1;
        check_all("rnd_clr");
        rst_n = 1'b1;
      end
      tick("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
